// File: rtl/matrix_loader.sv
// ============================================================================
// Module      : matrix_loader
// Description : Streams hash-matrix rows into a shadow copy and commits the
//               whole set to the active matrices in one cycle.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module matrix_loader #(
    parameter int NUMBER_OF_TABLES = 4,
    parameter int HASH_ADR_WIDTH   = 5,
    parameter int KEY_WIDTH        = 6
) (
    input  logic                                               clk,
    input  logic                                               reset,
    input  logic                                               start_i,
    input  logic                                               abort_i,
    input  logic [KEY_WIDTH-1:0]                               row_i,
    input  logic                                               row_valid_i,
    output logic                                               row_ready_o,
    output logic                                               busy_o,
    output logic                                               done_o,
    output logic [NUMBER_OF_TABLES*HASH_ADR_WIDTH*KEY_WIDTH-1:0] matrixes_o
);

    localparam int c_N  = NUMBER_OF_TABLES * HASH_ADR_WIDTH;
    localparam int c_W  = c_N * KEY_WIDTH;
    localparam int c_CW = (c_N > 1) ? $clog2(c_N) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(c_N - 1);

    // Generator default: row r carries a single bit at position r, if it fits.
    function automatic logic [c_W-1:0] default_matrix();
        logic [c_W-1:0] m;
        m = '0;
        for (int t = 0; t < NUMBER_OF_TABLES; t++) begin
            for (int r = 0; r < HASH_ADR_WIDTH; r++) begin
                if (r < KEY_WIDTH) begin
                    m[(t * HASH_ADR_WIDTH + r) * KEY_WIDTH + r] = 1'b1;
                end
            end
        end
        return m;
    endfunction

    localparam logic [c_W-1:0] c_DEFAULT = default_matrix();

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [c_CW-1:0]       r_count;
    logic [KEY_WIDTH-1:0]  r_shadow [c_N];
    logic [c_W-1:0]        r_active;
    logic                  r_done;
    logic                  w_hs;
    logic                  w_last;
    logic                  w_ready;
    logic                  w_busy;

    // Abort takes priority, so an aborted cycle never counts as a handshake.
    assign w_hs   = (r_state == S_LOAD) && row_valid_i && !abort_i;
    assign w_last = w_hs && (r_count == c_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_ready      = 1'b0;
        w_busy       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                w_ready = 1'b1;
                w_busy  = 1'b1;
                if (abort_i) begin
                    w_next_state = S_IDLE;
                end else if (w_last) begin
                    w_next_state = S_COMMIT;
                end
            end
            S_COMMIT: begin
                w_busy       = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if ((r_state != S_LOAD) || abort_i || w_last) begin
            r_count <= '0;
        end else if (w_hs) begin
            r_count <= r_count + 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < c_N; gi++) begin : g_slot
            localparam logic [c_CW-1:0] c_IDX = c_CW'(gi);
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_shadow[gi] <= c_DEFAULT[gi*KEY_WIDTH +: KEY_WIDTH];
                end else if (w_hs && (r_count == c_IDX)) begin
                    r_shadow[gi] <= row_i;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_active <= c_DEFAULT;
            r_done   <= 1'b0;
        end else begin
            r_done <= (r_state == S_COMMIT);
            if (r_state == S_COMMIT) begin
                for (int s = 0; s < c_N; s++) begin
                    r_active[s*KEY_WIDTH +: KEY_WIDTH] <= r_shadow[s];
                end
            end
        end
    end

    assign row_ready_o = w_ready;
    assign busy_o      = w_busy;
    assign done_o      = r_done;
    assign matrixes_o  = r_active;

endmodule

`default_nettype wire

// File: tb/tb_matrix_loader.sv
// ============================================================================
// Module      : tb_matrix_loader
// Description : Randomised bench for matrix_loader against a queue-based model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_matrix_loader;

    localparam int NT  = 4;
    localparam int HAW = 5;
    localparam int KW  = 6;
    localparam int N   = NT * HAW;
    localparam int W   = N * KW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start_i;
    logic          abort_i;
    logic [KW-1:0] row_i;
    logic          row_valid_i;
    logic          row_ready_o;
    logic          busy_o;
    logic          done_o;
    logic [W-1:0]  matrixes_o;

    always #5 clk = ~clk;

    matrix_loader #(
        .NUMBER_OF_TABLES (NT),
        .HASH_ADR_WIDTH   (HAW),
        .KEY_WIDTH        (KW)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .row_i       (row_i),
        .row_valid_i (row_valid_i),
        .row_ready_o (row_ready_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .matrixes_o  (matrixes_o)
    );

    int            n_cmp      = 0;
    int            n_err      = 0;
    int            done_count = 0;
    bit            checking   = 1'b0;
    logic [KW-1:0] data [N];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [KW-1:0] slot(input int s);
        return matrixes_o[s*KW +: KW];
    endfunction

    function automatic logic [W-1:0] identity();
        logic [W-1:0] m;
        int v;
        m = '0;
        for (int t = 0; t < NT; t++) begin
            for (int r = 0; r < HAW; r++) begin
                v = (r < KW) ? (1 << r) : 0;
                m[(t*HAW + r)*KW +: KW] = v[KW-1:0];
            end
        end
        return m;
    endfunction

    // Reference: collect accepted rows in a queue; a full queue publishes one cycle later.
    logic [W-1:0]  m_active;
    bit            m_loading;
    bit            m_commit;
    bit            m_done;
    logic [KW-1:0] m_rows [$];

    always @(posedge clk) begin
        if (reset) begin
            m_active  = identity();
            m_loading = 1'b0;
            m_commit  = 1'b0;
            m_done    = 1'b0;
            m_rows.delete();
        end else begin
            m_done = 1'b0;
            if (m_commit) begin
                for (int s = 0; s < N; s++) m_active[s*KW +: KW] = m_rows[s];
                m_rows.delete();
                m_commit = 1'b0;
                m_done   = 1'b1;
            end else if (m_loading) begin
                if (abort_i) begin
                    m_loading = 1'b0;
                    m_rows.delete();
                end else if (row_valid_i) begin
                    m_rows.push_back(row_i);
                    if (m_rows.size() == N) begin
                        m_loading = 1'b0;
                        m_commit  = 1'b1;
                    end
                end
            end else if (start_i) begin
                m_loading = 1'b1;
                m_rows.delete();
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("matrixes_o", matrixes_o, m_active);
            chk("busy_o", W'(busy_o), W'(m_loading | m_commit));
            chk("row_ready_o", W'(row_ready_o), W'(m_loading));
            chk("done_o", W'(done_o), W'(m_done));
            if (done_o === 1'b1) done_count++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_load(input bit toggle, input bit rnd_valid, input int abort_at,
                            input int reset_at, input int start_pulse_at, input bit commit_start);
        int hs  = 0;
        int cyc = 0;
        bit v;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        while (hs < N && cyc < 400) begin
            v = toggle ? (cyc % 2 == 0) : (rnd_valid ? ($urandom_range(0, 2) != 0) : 1'b1);
            row_valid_i = v;
            row_i       = data[hs];
            abort_i     = v && (hs == abort_at);
            reset       = (hs == reset_at);
            start_i     = (cyc == start_pulse_at);
            step();
            cyc++;
            if (abort_i || reset) begin
                abort_i     = 1'b0;
                reset       = 1'b0;
                row_valid_i = 1'b0;
                start_i     = 1'b0;
                return;
            end
            if (v) hs++;
        end
        row_valid_i = 1'b0;
        start_i     = commit_start;
        step();
        start_i     = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        for (int k = 0; k < 8 && done_count == d0; k++) step();
        step();
        step();
    endtask

    task automatic check_identity(input string name);
        int id [HAW] = '{1, 2, 4, 8, 16};
        for (int t = 0; t < NT; t++)
            for (int r = 0; r < HAW; r++)
                chk(name, W'(slot(t*HAW + r)), W'(id[r]));
    endtask

    initial begin
        int d0;
        reset       = 1'b1;
        start_i     = 1'b0;
        abort_i     = 1'b0;
        row_valid_i = 1'b0;
        row_i       = '0;
        step();
        checking = 1'b1;
        step();
        reset = 1'b0;

        // Default matrices after reset
        repeat (5) step();
        check_identity("t1_default_row");
        chk("t1_busy", W'(busy_o), '0);
        chk("t1_ready", W'(row_ready_o), '0);

        // Back-to-back ramp load
        for (int s = 0; s < N; s++) data[s] = KW'(s + 1);
        d0 = done_count;
        run_load(1'b0, 1'b0, -1, -1, -1, 1'b0);
        wait_done(d0);
        chk("t2_done_pulses", W'(done_count - d0), W'(1));
        chk("t2_table2_row3", W'(slot(2*HAW + 3)), W'(6'h0E));
        for (int s = 0; s < N; s++) chk("t2_ramp", W'(slot(s)), W'(s + 1));

        // Same load with gapped valid
        d0 = done_count;
        run_load(1'b1, 1'b0, -1, -1, -1, 1'b0);
        wait_done(d0);
        chk("t3_done_pulses", W'(done_count - d0), W'(1));
        for (int s = 0; s < N; s++) chk("t3_ramp", W'(slot(s)), W'(s + 1));

        // Abort on the 7th row, then a clean full load
        for (int s = 0; s < N; s++) data[s] = KW'(63 - s);
        d0 = done_count;
        run_load(1'b0, 1'b0, 6, -1, -1, 1'b0);
        repeat (4) step();
        chk("t4_abort_no_done", W'(done_count - d0), '0);
        chk("t4_abort_keep", W'(slot(2*HAW + 3)), W'(6'h0E));
        run_load(1'b0, 1'b0, -1, -1, -1, 1'b0);
        wait_done(d0);
        chk("t4_reload_done", W'(done_count - d0), W'(1));
        for (int s = 0; s < N; s++) chk("t4_reload", W'(slot(s)), W'(63 - s));

        // Reset in the middle of a load
        for (int s = 0; s < N; s++) data[s] = KW'($urandom);
        d0 = done_count;
        run_load(1'b0, 1'b0, -1, 10, -1, 1'b0);
        repeat (6) step();
        chk("t5_reset_no_done", W'(done_count - d0), '0);
        check_identity("t5_reset_default");

        // Rows in IDLE, stray start pulses in LOAD and COMMIT
        row_valid_i = 1'b1;
        row_i       = 6'h2A;
        repeat (3) step();
        row_valid_i = 1'b0;
        for (int s = 0; s < N; s++) data[s] = KW'((s * 3 + 5) % 64);
        d0 = done_count;
        run_load(1'b0, 1'b0, -1, -1, 4, 1'b1);
        wait_done(d0);
        chk("t6_done_pulses", W'(done_count - d0), W'(1));
        chk("t6_idle_after", W'(busy_o), '0);
        for (int s = 0; s < N; s++) chk("t6_rows", W'(slot(s)), W'((s * 3 + 5) % 64));

        // Randomised loads with occasional aborts
        repeat (25) begin
            for (int s = 0; s < N; s++) data[s] = KW'($urandom);
            run_load(1'b0, 1'b1,
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 1)) : -1,
                     -1, -1, 1'(($urandom_range(0, 1))));
            repeat ($urandom_range(1, 4)) step();
        end

        repeat (4) step();
        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
